// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the seven-segment display blocks.
//   NUM_DIGITS   : number of digits on the display module
//   bcd_t        : one 4-bit BCD digit
//   SEG_*        : active-high {g,f,e,d,c,b,a} patterns
//   isZero()     : helper used by leading-zero suppression
// ---------------------------------------------------------------------------
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    function automatic logic isZero(input bcd_t d);
        return (d == 4'd0);
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// ---------------------------------------------------------------------------
// bcd_to_seg7
// Purely combinational BCD to seven-segment decoder.
// Ports:
//   i_code : 4-bit BCD code
//   o_seg  : active-high {g,f,e,d,c,b,a} pattern; codes 10..15 show a dash
// ---------------------------------------------------------------------------
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  bcd_t       i_code,
    output logic [6:0] o_seg
);

    // Non-decimal codes fall through to a dash so bad input is visible
    // on the display rather than showing a misleading digit.
    always_comb begin
        o_seg = SEG_DASH;
        case (i_code)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexes four BCD digits onto a common-anode 4-digit display.
// Ports:
//   clk    : system clock
//   rst    : asynchronous active-high reset
//   digits : packed BCD, [3:0] = digit0 ... [15:12] = digit3
//   dp_in  : decimal-point request, bit n = digit n
//   lz_en  : leading-zero suppression enable
//   seg    : segment drive {g,f,e,d,c,b,a}
//   dp     : decimal-point drive
//   an     : digit enable, bit n = digit n
// All internal logic is active-high; polarity parameters only affect pins.
// ---------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int SLOT_CYCLES    = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_in,
    input  logic        lz_en,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    localparam int             PW        = $clog2(SLOT_CYCLES);
    localparam logic [PW-1:0]  LAST      = PW'(SLOT_CYCLES - 1);
    localparam logic [PW-1:0]  BLANK_END = PW'(BLANK_CYCLES);

    logic [PW-1:0] r_presc;
    logic [1:0]    r_slot;
    logic [15:0]   r_shDigits;
    logic [3:0]    r_shDp;
    logic          r_shLz;
    logic [3:0]    r_anOn;
    logic [6:0]    r_segOn;
    logic          r_dpOn;

    logic          w_terminal;
    bcd_t          w_digit;
    logic [6:0]    w_pattern;
    logic          w_suppress;
    logic          w_show;

    assign w_terminal = (r_presc == LAST);

    // Prescaler divides clk down to one slot; the slot index steps once
    // per prescaler wrap and naturally wraps 3 -> 0 in two bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_slot  <= 2'd0;
        end else if (w_terminal) begin
            r_presc <= '0;
            r_slot  <= r_slot + 2'd1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Inputs are sampled only at the very end of a frame so one whole
    // frame always shows a coherent set of digits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shDigits <= '0;
            r_shDp     <= '0;
            r_shLz     <= 1'b0;
        end else if (w_terminal && (r_slot == 2'd3)) begin
            r_shDigits <= digits;
            r_shDp     <= dp_in;
            r_shLz     <= lz_en;
        end
    end

    assign w_digit = r_shDigits[{r_slot, 2'b00} +: 4];

    bcd_to_seg7 u_decode (
        .i_code (w_digit),
        .o_seg  (w_pattern)
    );

    // A digit is a leading zero only if it and every more significant
    // digit are zero; digit0 is always shown.
    always_comb begin
        w_suppress = 1'b0;
        if (r_shLz) begin
            case (r_slot)
                2'd3: w_suppress = isZero(r_shDigits[15:12]);
                2'd2: w_suppress = isZero(r_shDigits[15:12]) &&
                                   isZero(r_shDigits[11:8]);
                2'd1: w_suppress = isZero(r_shDigits[15:12]) &&
                                   isZero(r_shDigits[11:8]) &&
                                   isZero(r_shDigits[7:4]);
                default: w_suppress = 1'b0;
            endcase
        end
    end

    // The first BLANK_CYCLES of each slot keep every anode off so the
    // previous digit's segments cannot ghost onto the next digit.
    assign w_show = (r_presc >= BLANK_END) && !w_suppress;

    // Registered drive removes decode glitches from the pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_anOn  <= 4'b0000;
            r_segOn <= SEG_OFF;
            r_dpOn  <= 1'b0;
        end else if (w_show) begin
            r_anOn  <= 4'b0001 << r_slot;
            r_segOn <= w_pattern;
            r_dpOn  <= r_shDp[r_slot];
        end else begin
            r_anOn  <= 4'b0000;
            r_segOn <= SEG_OFF;
            r_dpOn  <= 1'b0;
        end
    end

    assign seg = SEG_ACTIVE_LOW ? ~r_segOn : r_segOn;
    assign dp  = SEG_ACTIVE_LOW ? ~r_dpOn  : r_dpOn;
    assign an  = AN_ACTIVE_LOW  ? ~r_anOn  : r_anOn;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_driver
// Scoreboard bench for seg7_scan_driver with 8-cycle slots and 2 blank
// cycles. The stimulus process pushes the hand-decoded windows each frame
// should show; the monitor pops one entry per lit-anode window and checks
// pins, window length and the all-off state between windows.
// ---------------------------------------------------------------------------
module tb_seg7_scan_driver;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } win_t;

    typedef struct {
        logic [15:0] digits;
        logic [3:0]  dpReq;
        logic        lz;
        int          off;
        logic [3:0]  lit;
        logic [27:0] segs;
        logic [3:0]  dpPins;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [15:0] digits;
    logic [3:0]  dpIn;
    logic        lzEn;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    bit   monEn = 1'b0;
    win_t q[$];
    vec_t vecs[9];

    seg7_scan_driver #(
        .SLOT_CYCLES    (8),
        .BLANK_CYCLES   (2),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .digits (digits),
        .dp_in  (dpIn),
        .lz_en  (lzEn),
        .seg    (seg),
        .dp     (dp),
        .an     (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Queue the lit windows of one frame in slot order.
    task automatic pushFrame(input logic [3:0] lit, input logic [27:0] segs,
                             input logic [3:0] dpPins);
        win_t       w;
        logic [3:0] oneHot;
        for (int s = 0; s < 4; s++) begin
            if (lit[s]) begin
                oneHot = 4'b0001 << s;
                w.an   = ~oneHot;
                w.seg  = segs[s*7 +: 7];
                w.dp   = dpPins[s];
                q.push_back(w);
            end
        end
    endtask

    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] p, input logic l);
        digits = d;
        dpIn   = p;
        lzEn   = l;
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Monitor: each run of cycles with one anode on is one display window.
    win_t cur;
    bit   inWin  = 1'b0;
    int   winLen = 0;

    always @(negedge clk) begin
        if (rst) begin
            inWin = 1'b0;
        end else if (monEn) begin
            if (an === 4'b1111) begin
                if (inWin) begin
                    checkOutput("winLen", 8'(winLen), 8'd6);
                    inWin = 1'b0;
                end
                checkOutput("idleSeg", {1'b0, seg}, 8'h7F);
                checkOutput("idleDp", {7'b0, dp}, 8'h01);
            end else begin
                if (!(an === 4'b1110 || an === 4'b1101 || an === 4'b1011 || an === 4'b0111))
                    checkOutput("anOneHot", {4'b0, an}, 8'h0E);
                if (inWin && an !== cur.an) begin
                    checkOutput("winLen", 8'(winLen), 8'd6);
                    inWin = 1'b0;
                end
                if (!inWin) begin
                    if (q.size() == 0) begin
                        checkOutput("winUnexpected", {4'b0, an}, 8'h0F);
                        cur.an  = 4'b1111;
                        cur.seg = 7'h7F;
                        cur.dp  = 1'b1;
                    end else begin
                        cur = q.pop_front();
                    end
                    inWin  = 1'b1;
                    winLen = 0;
                end
                winLen++;
                checkOutput("winAn", {4'b0, an}, {4'b0, cur.an});
                checkOutput("winSeg", {1'b0, seg}, {1'b0, cur.seg});
                checkOutput("winDp", {7'b0, dp}, {7'b0, cur.dp});
            end
        end
    end

    initial begin
        // digits, dp_in, lz_en, apply offset in frame, lit mask,
        // {slot3,slot2,slot1,slot0} segment pins, dp pins
        vecs[0] = '{16'h1234, 4'b0000, 1'b0, 4,  4'b1111, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111};
        vecs[1] = '{16'h1234, 4'b0000, 1'b0, 4,  4'b1111, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111};
        vecs[2] = '{16'h9999, 4'b0000, 1'b0, 10, 4'b1111, {7'h10, 7'h10, 7'h10, 7'h10}, 4'b1111};
        vecs[3] = '{16'h0050, 4'b0000, 1'b1, 4,  4'b0011, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1111};
        vecs[4] = '{16'h0050, 4'b0000, 1'b0, 4,  4'b1111, {7'h40, 7'h40, 7'h12, 7'h40}, 4'b1111};
        vecs[5] = '{16'h00A0, 4'b0000, 1'b0, 4,  4'b1111, {7'h40, 7'h40, 7'h3F, 7'h40}, 4'b1111};
        vecs[6] = '{16'h8888, 4'b0100, 1'b0, 4,  4'b1111, {7'h00, 7'h00, 7'h00, 7'h00}, 4'b1011};
        vecs[7] = '{16'h0005, 4'b0100, 1'b1, 4,  4'b0001, {7'h7F, 7'h7F, 7'h7F, 7'h12}, 4'b1111};
        vecs[8] = '{16'h0305, 4'b0000, 1'b1, 4,  4'b0111, {7'h7F, 7'h30, 7'h40, 7'h12}, 4'b1111};

        rst = 1'b1;
        applyStimulus(16'h0000, 4'b0000, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("rstAn", {4'b0, an}, 8'h0F);
        checkOutput("rstSeg", {1'b0, seg}, 8'h7F);
        checkOutput("rstDp", {7'b0, dp}, 8'h01);

        // Run into slot 2 of the first frame, then reset between edges.
        rst = 1'b0;
        applyStimulus(16'h1234, 4'b1111, 1'b0);
        repeat (21) @(negedge clk);
        checkOutput("preRstAn", {4'b0, an}, 8'h0B);
        checkOutput("preRstSeg", {1'b0, seg}, 8'h40);
        #2 rst = 1'b1;
        #1;
        checkOutput("asyncRstAn", {4'b0, an}, 8'h0F);
        checkOutput("asyncRstSeg", {1'b0, seg}, 8'h7F);
        checkOutput("asyncRstDp", {7'b0, dp}, 8'h01);
        repeat (2) @(negedge clk);

        rst   = 1'b0;
        cyc   = 0;
        monEn = 1'b1;
        pushFrame(4'b1111, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111);

        waitUntil(2);
        checkOutput("slot0Early", {4'b0, an}, 8'h0F);
        waitUntil(3);
        checkOutput("slot0Start", {4'b0, an}, 8'h0E);

        // Vector i is applied during frame i and displayed in frame i+1.
        for (int i = 0; i < 9; i++) begin
            waitUntil(32 * i + vecs[i].off);
            applyStimulus(vecs[i].digits, vecs[i].dpReq, vecs[i].lz);
            pushFrame(vecs[i].lit, vecs[i].segs, vecs[i].dpPins);
        end

        waitUntil(322);
        monEn = 1'b0;
        checkOutput("queueEmpty", 8'(q.size()), 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
